// File: rtl/ssd_scan_if.sv
// ssd_scan_if: scanned seven-segment display bus.
// The master side drives the anode scan and segment lines and observes the
// decoded frame. The slave side (the decoder) does the opposite.
interface ssd_scan_if;
    logic [3:0]  ssd_ctrl;       // anode enables, active-low, bit0 = rightmost digit
    logic [6:0]  show;           // segments {a,b,c,d,e,f,g}, active-low
    logic [15:0] digits;         // last complete frame {d3,d2,d1,d0}
    logic        frame_valid;    // pulse: digits just updated
    logic        pat_err;        // pulse: stable undecodable pattern rejected
    logic        frame_timeout;  // pulse: watchdog expired

    modport master (
        output ssd_ctrl, show,
        input  digits, frame_valid, pat_err, frame_timeout
    );

    modport slave (
        input  ssd_ctrl, show,
        output digits, frame_valid, pat_err, frame_timeout
    );
endinterface

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers the four BCD digits shown on a multiplexed
// seven-segment display by watching the anode scan and segment lines.
// A digit is accepted once its (select, pattern) pair has been sampled
// STABLE_CYCLES times in a row; a frame is published when all four slots
// have been accepted since the last frame.
// Optional watchdog: define SSD_SCAN_DECODER_TIMEOUT_EN to enable the
// frame_timeout pulse after TIMEOUT_CYCLES cycles without a frame.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic      clk,
    input logic      rst,
    ssd_scan_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    // Reject configurations the counter widths cannot represent.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("ssd_scan_decoder: STABLE_CYCLES must be 2..255, TIMEOUT_CYCLES >= 2");
    end

    // Sample stage and the previously sampled pair used for stability checks.
    logic [3:0]  ctrl_q, ctrl_d, ctrl_prev_q, ctrl_prev_d;
    logic [6:0]  show_q, show_d, show_prev_q, show_prev_d;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] slots_q, slots_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] digits_q, digits_d;
    logic        frame_valid_q, frame_valid_d;
    logic        pat_err_q, pat_err_d;

    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        pat_ok;
    logic [3:0]  nib;
    logic        same;
    logic        accept;

`ifdef SSD_SCAN_DECODER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            frame_timeout_q, frame_timeout_d;
`endif

    // Decode the sampled select (exactly one low bit) and segment pattern.
    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (ctrl_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase

        pat_ok = 1'b1;
        nib    = 4'h0;
        case (show_q)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b1111111: nib = 4'hF;   // blanked digit
            default:    pat_ok = 1'b0;
        endcase

        same = (ctrl_q == ctrl_prev_q) && (show_q == show_prev_q);
    end

    // Stability FSM: one acceptance per dwell of an unchanged sampled pair.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            WAIT: begin
                if (sel_valid) begin
                    state_d = COUNT;
                    cnt_d   = 8'd1;
                end
            end
            COUNT, HELD: begin
                if (!same) begin
                    if (sel_valid) begin
                        state_d = COUNT;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 8'd0;
                    end
                end else if (state_q == COUNT) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == STABLE_N) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Slot/frame bookkeeping, sample stage and optional watchdog.
    always_comb begin
        ctrl_d        = bus.ssd_ctrl;
        show_d        = bus.show;
        ctrl_prev_d   = ctrl_q;
        show_prev_d   = show_q;
        slots_d       = slots_q;
        seen_d        = seen_q;
        digits_d      = digits_q;
        frame_valid_d = 1'b0;
        pat_err_d     = 1'b0;

        if (accept) begin
            if (pat_ok) begin
                slots_d[{sel_idx, 2'b00} +: 4] = nib;
                seen_d = seen_q | (4'b0001 << sel_idx);
                if (seen_d == 4'hF) begin
                    // All slots fresh: publish atomically and start over.
                    digits_d      = slots_d;
                    frame_valid_d = 1'b1;
                    seen_d        = 4'h0;
                end
            end else begin
                pat_err_d = 1'b1;
            end
        end

`ifdef SSD_SCAN_DECODER_TIMEOUT_EN
        // A completed frame on the same edge wins over expiry.
        frame_timeout_d = 1'b0;
        wd_d            = wd_q + 1'b1;
        if (frame_valid_d) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_d            = '0;
            frame_timeout_d = 1'b1;
            seen_d          = 4'h0;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q        <= 4'hF;
            show_q        <= 7'h7F;
            ctrl_prev_q   <= 4'hF;
            show_prev_q   <= 7'h7F;
            state_q       <= WAIT;
            cnt_q         <= 8'd0;
            slots_q       <= 16'h0000;
            seen_q        <= 4'h0;
            digits_q      <= 16'h0000;
            frame_valid_q <= 1'b0;
            pat_err_q     <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            show_q        <= show_d;
            ctrl_prev_q   <= ctrl_prev_d;
            show_prev_q   <= show_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slots_q       <= slots_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            pat_err_q     <= pat_err_d;
        end
    end

`ifdef SSD_SCAN_DECODER_TIMEOUT_EN
    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q            <= '0;
            frame_timeout_q <= 1'b0;
        end else begin
            wd_q            <= wd_d;
            frame_timeout_q <= frame_timeout_d;
        end
    end

    assign bus.frame_timeout = frame_timeout_q;
`else
    assign bus.frame_timeout = 1'b0;
`endif

    assign bus.digits      = digits_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pat_err     = pat_err_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed scenarios plus random scanning, checked
// against a run-length reference model of the display decoder.
module tb_ssd_scan_decoder;
    localparam int S = 4;
    localparam int T = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssd_scan_if bus ();

    ssd_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Segment codes for 0..9, index 10 = blank.
    logic [6:0] seg_tab [0:10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                   7'b0000000, 7'b0000100, 7'b1111111};

    // Reference model state.
    logic [3:0]  m_slot [4];
    bit          m_seen [4];
    logic [15:0] m_digits;
    bit          m_fv, m_pe, m_to;
    int          m_wd, m_run;
    logic [3:0]  m_pc, m_acc_c;
    logic [6:0]  m_ps, m_acc_s;
    bit          m_pend;

    // Observation of the last dwell(s).
    int          dev, fv_cnt, pe_cnt, to_cnt, cyc, fv_cyc, to_cyc;
    logic [18:0] dev_got, dev_want;

    function automatic int sel_of(input logic [3:0] c);
        logic [3:0] one;
        for (int i = 0; i < 4; i++) begin
            one = 4'b0001 << i;
            if (c == ~one) return i;
        end
        return -1;
    endfunction

    function automatic int dec_of(input logic [6:0] s);
        for (int i = 0; i < 11; i++)
            if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = 4'h0;
            m_seen[i] = 1'b0;
        end
        m_digits = 16'h0000;
        m_fv = 0; m_pe = 0; m_to = 0;
        m_wd = 0; m_run = 0; m_pend = 0;
        m_pc = 4'hF; m_ps = 7'h7F;
        m_acc_c = 4'hF; m_acc_s = 7'h7F;
    endtask

    // One clock edge of the model: a pair seen S times in a row with a valid
    // select is acted on at the following edge.
    task automatic model_edge(input logic [3:0] c, input logic [6:0] s);
        int k, d;
        m_fv = 0; m_pe = 0; m_to = 0;
        if (m_pend) begin
            k = sel_of(m_acc_c);
            d = dec_of(m_acc_s);
            if (d < 0) m_pe = 1;
            else begin
                m_slot[k] = (d == 10) ? 4'hF : 4'(d);
                m_seen[k] = 1'b1;
                if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                    m_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                    m_fv = 1;
                    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
                end
            end
        end
`ifdef SSD_SCAN_DECODER_TIMEOUT_EN
        if (m_fv) m_wd = 0;
        else if (m_wd + 1 == T) begin
            m_wd = 0;
            m_to = 1;
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        end else m_wd++;
`endif
        if (c == m_pc && s == m_ps) m_run++;
        else m_run = 1;
        m_pc = c; m_ps = s;
        m_pend  = (m_run == S) && (sel_of(c) >= 0);
        m_acc_c = c; m_acc_s = s;
    endtask

    task automatic clear_obs();
        dev = 0; fv_cnt = 0; pe_cnt = 0; to_cnt = 0;
        fv_cyc = -1; to_cyc = -1;
        dev_got = '0; dev_want = '0;
    endtask

    // Hold one pair for n cycles, recording pulses and model deviations.
    task automatic dwell(input logic [3:0] c, input logic [6:0] s, input int n);
        logic [18:0] got, want;
        for (int i = 0; i < n; i++) begin
            bus.ssd_ctrl = c;
            bus.show     = s;
            @(posedge clk);
            model_edge(c, s);
            #1;
            cyc++;
            got  = {bus.digits, bus.frame_valid, bus.pat_err, bus.frame_timeout};
            want = {m_digits, m_fv, m_pe, m_to};
            if (got !== want) begin
                if (dev == 0) begin dev_got = got; dev_want = want; end
                dev++;
            end
            if (bus.frame_valid)   begin fv_cnt++; fv_cyc = cyc; end
            if (bus.pat_err)       pe_cnt++;
            if (bus.frame_timeout) begin to_cnt++; to_cyc = cyc; end
        end
    endtask

    task automatic scan(input logic [15:0] v, input int n);
        logic [3:0] c, one;
        for (int k = 0; k < 4; k++) begin
            one = 4'b0001 << k;
            c = ~one;
            dwell(c, seg_tab[v[4*k +: 4]], n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.ssd_ctrl = 4'($urandom);
        bus.show     = 7'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        model_reset();
        #1;
        n_cmp++;
        if (bus.digits !== 16'h0000) begin
            n_bad++; $display("FAIL reset_digits: got %h want 0000", bus.digits);
        end
        n_cmp++;
        if ({bus.frame_valid, bus.pat_err, bus.frame_timeout} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000",
                              {bus.frame_valid, bus.pat_err, bus.frame_timeout});
        end
        rst = 1'b0;
        clear_obs();
        dwell(4'b1110, seg_tab[1], 1);
        n_cmp++;
        if (fv_cnt + pe_cnt + to_cnt !== 0) begin
            n_bad++; $display("FAIL reset_after: got %0d pulses want 0", fv_cnt + pe_cnt + to_cnt);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        clear_obs();
        scan(16'h1234, 8);
        dwell(4'hF, 7'h7F, 2);
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL basic_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
        n_cmp++;
        if (fv_cnt !== 1) begin
            n_bad++; $display("FAIL basic_fv_count: got %0d want 1", fv_cnt);
        end
        n_cmp++;
        if (bus.digits !== 16'h1234) begin
            n_bad++; $display("FAIL basic_digits: got %h want 1234", bus.digits);
        end
        n_cmp++;
        if (pe_cnt !== 0) begin
            n_bad++; $display("FAIL basic_pat_err: got %0d want 0", pe_cnt);
        end
    endtask

    task automatic test_dwell_length();
        int c0;
        do_reset();
        clear_obs();
        dwell(4'b1110, seg_tab[7], 3);
        dwell(4'b1101, seg_tab[6], 8);
        dwell(4'b1011, seg_tab[5], 8);
        dwell(4'b0111, seg_tab[4], 8);
        n_cmp++;
        if (fv_cnt !== 0) begin
            n_bad++; $display("FAIL short_dwell: got %0d frames want 0", fv_cnt);
        end
        c0 = cyc;
        dwell(4'b1110, seg_tab[7], 5);
        n_cmp++;
        if (fv_cyc - c0 !== S + 1) begin
            n_bad++; $display("FAIL accept_edge: got step %0d want %0d", fv_cyc - c0, S + 1);
        end
        n_cmp++;
        if (bus.digits !== 16'h4567) begin
            n_bad++; $display("FAIL dwell_digits: got %h want 4567", bus.digits);
        end
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL dwell_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
    endtask

    task automatic test_pat_err();
        do_reset();
        clear_obs();
        dwell(4'b1110, seg_tab[8], 6);
        dwell(4'b1101, seg_tab[6], 6);
        dwell(4'b1011, 7'b1111110, 6);
        dwell(4'b0111, seg_tab[2], 6);
        n_cmp++;
        if (pe_cnt !== 1) begin
            n_bad++; $display("FAIL pat_err_count: got %0d want 1", pe_cnt);
        end
        n_cmp++;
        if (fv_cnt !== 0) begin
            n_bad++; $display("FAIL pat_err_frame: got %0d frames want 0", fv_cnt);
        end
        scan(16'h2468, 6);
        n_cmp++;
        if (fv_cnt !== 1 || bus.digits !== 16'h2468) begin
            n_bad++; $display("FAIL pat_err_recover: got %0d frames digits %h want 1 frame 2468",
                              fv_cnt, bus.digits);
        end
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL pat_err_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
    endtask

    task automatic test_no_select();
        do_reset();
        clear_obs();
        dwell(4'b1100, seg_tab[1], 20);
        dwell(4'b1111, seg_tab[2], 20);
        n_cmp++;
        if (fv_cnt + pe_cnt !== 0) begin
            n_bad++; $display("FAIL no_select: got %0d pulses want 0", fv_cnt + pe_cnt);
        end
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL no_select_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        clear_obs();
        scan(16'h1234, 8);
        dwell(4'b1110, seg_tab[9], 8);
        dwell(4'b1101, seg_tab[9], 8);
        dwell(4'b1011, seg_tab[9], 8);
        do_reset();
        n_cmp++;
        if (bus.digits !== 16'h0000) begin
            n_bad++; $display("FAIL mid_reset_digits: got %h want 0000", bus.digits);
        end
        clear_obs();
        scan(16'h5678, 8);
        dwell(4'hF, 7'h7F, 2);
        n_cmp++;
        if (fv_cnt !== 1 || bus.digits !== 16'h5678) begin
            n_bad++; $display("FAIL mid_reset_frame: got %0d frames digits %h want 1 frame 5678",
                              fv_cnt, bus.digits);
        end
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL mid_reset_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        clear_obs();
        scan(16'h1357, 8);
        dwell(4'b1110, seg_tab[2], 8);
        dwell(4'b1101, seg_tab[4], 8);
        dwell(4'hF, 7'h7F, 60);
`ifdef SSD_SCAN_DECODER_TIMEOUT_EN
        n_cmp++;
        if (to_cnt !== 1 || to_cyc - fv_cyc !== T) begin
            n_bad++; $display("FAIL timeout_pulse: got %0d pulses at +%0d want 1 at +%0d",
                              to_cnt, to_cyc - fv_cyc, T);
        end
`else
        n_cmp++;
        if (to_cnt !== 0) begin
            n_bad++; $display("FAIL timeout_off: got %0d pulses want 0", to_cnt);
        end
`endif
        n_cmp++;
        if (bus.digits !== 16'h1357) begin
            n_bad++; $display("FAIL timeout_digits: got %h want 1357", bus.digits);
        end
        // Finishing the scan completes a frame only if progress survived.
        dwell(4'b1011, seg_tab[6], 8);
        dwell(4'b0111, seg_tab[8], 8);
`ifdef SSD_SCAN_DECODER_TIMEOUT_EN
        n_cmp++;
        if (fv_cnt !== 1) begin
            n_bad++; $display("FAIL timeout_seen_clear: got %0d frames want 1", fv_cnt);
        end
`else
        n_cmp++;
        if (fv_cnt !== 2 || bus.digits !== 16'h8642) begin
            n_bad++; $display("FAIL seen_kept: got %0d frames digits %h want 2 frames 8642",
                              fv_cnt, bus.digits);
        end
`endif
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL timeout_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
    endtask

    task automatic test_random();
        logic [3:0] c, one;
        logic [6:0] s;
        int pick;
        do_reset();
        clear_obs();
        for (int i = 0; i < 200; i++) begin
            pick = $urandom_range(0, 5);
            if (pick < 4) begin
                one = 4'b0001 << pick;
                c = ~one;
            end else if (pick == 4) c = 4'($urandom);
            else c = 4'hF;
            pick = $urandom_range(0, 12);
            s = (pick <= 10) ? seg_tab[pick] : 7'($urandom);
            dwell(c, s, $urandom_range(1, 7));
        end
        n_cmp++;
        if (dev !== 0) begin
            n_bad++; $display("FAIL random_model: %0d cycles off, got %h want %h", dev, dev_got, dev_want);
        end
    endtask

    initial begin
        cyc = 0;
        bus.ssd_ctrl = 4'hF;
        bus.show     = 7'h7F;
        rst = 1'b1;
        model_reset();
        clear_obs();
        test_reset();
        test_basic_frame();
        test_dwell_length();
        test_pat_err();
        test_no_select();
        test_reset_mid_frame();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
